fifo_write_arbiter: RTL and testbench



---
 rtl/fifo_write_arb_pkg.sv | 20 ++
 rtl/fifo_write_arbiter_rr_picker.sv | 36 +++
 rtl/fifo_write_arbiter.sv | 150 +++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_write_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_write_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    STALL = 2'd2
  } arb_state_t;

  // Requester index width: $clog2(NUM_REQ), never narrower than one bit.
  function automatic int req_idx_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Burst counter width: $clog2(MAX_BURST)+1, enough to hold MAX_BURST-1.
  function automatic int burst_cnt_width(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Combinational round-robin search: first set request strictly after
// last_grant, wrapping around.
module rr_picker
  import fifo_write_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int REQ_IDX_W = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [REQ_IDX_W-1:0] last_grant,
  output logic [NUM_REQ-1:0]   pick_onehot,
  output logic [REQ_IDX_W-1:0] pick_idx,
  output logic                 pick_valid
);

  // Scan the requesters in rotated order, keeping the first hit.
  always_comb begin
    pick_onehot = '0;
    pick_idx    = '0;
    pick_valid  = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      int cand;
      logic [REQ_IDX_W-1:0] cand_idx;
      cand     = (int'(last_grant) + off) % NUM_REQ;
      cand_idx = REQ_IDX_W'(cand);
      if (!pick_valid && req[cand_idx]) begin
        pick_valid            = 1'b1;
        pick_idx              = cand_idx;
        pick_onehot[cand_idx] = 1'b1;
      end else begin
        pick_valid = pick_valid;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter for the single FIFO write port.
// Optional stall cycle counter (stall_count / stall_clear ports) is built
// only when FIFO_WRITE_ARB_STALL_CNT_EN is defined.
module fifo_write_arbiter
  import fifo_write_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     write_clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     full_flag,
  input  logic                     almost_full_flag,
  output logic                     valid_write,
  output logic [WIDTH-1:0]         write_data,
`ifdef FIFO_WRITE_ARB_STALL_CNT_EN
  output logic [15:0]              stall_count,
  input  logic                     stall_clear,
`endif
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy
);

  localparam int REQ_IDX_W   = req_idx_width(NUM_REQ);
  localparam int BURST_CNT_W = burst_cnt_width(MAX_BURST);
  localparam logic [BURST_CNT_W-1:0] LAST_BEAT = BURST_CNT_W'(MAX_BURST - 1);
  localparam logic [REQ_IDX_W-1:0]   LAST_IDX  = REQ_IDX_W'(NUM_REQ - 1);

  arb_state_t             state_r;
  logic [NUM_REQ-1:0]     grant_r;
  logic [REQ_IDX_W-1:0]   owner_r;
  logic [REQ_IDX_W-1:0]   last_grant_r;
  logic [BURST_CNT_W-1:0] burst_cnt_r;

  logic [NUM_REQ-1:0]     pick_onehot_s;
  logic [REQ_IDX_W-1:0]   pick_idx_s;
  logic                   pick_valid_s;

  rr_picker #(
    .NUM_REQ   (NUM_REQ),
    .REQ_IDX_W (REQ_IDX_W)
  ) u_rr_picker (
    .req         (req),
    .last_grant  (last_grant_r),
    .pick_onehot (pick_onehot_s),
    .pick_idx    (pick_idx_s),
    .pick_valid  (pick_valid_s)
  );

  assign grant = grant_r;
  assign busy  = (state_r != IDLE);

  // Owner's handshake and data path; only BURST with a non-full FIFO moves words.
  always_comb begin
    req_ready   = '0;
    valid_write = 1'b0;
    write_data  = req_data[int'(owner_r)*WIDTH +: WIDTH];
    case (state_r)
      BURST: begin
        req_ready[owner_r] = ~full_flag;
        valid_write        = req_valid[owner_r] & ~full_flag;
      end
      IDLE, STALL: begin
        valid_write = 1'b0;
      end
      default: begin
        valid_write = 1'b0;
      end
    endcase
  end

  // Arbitration FSM: start bursts from IDLE, count beats, stall on full.
  always_ff @(posedge write_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      grant_r      <= '0;
      owner_r      <= '0;
      last_grant_r <= LAST_IDX;
      burst_cnt_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_valid_s && !almost_full_flag) begin
            state_r     <= BURST;
            grant_r     <= pick_onehot_s;
            owner_r     <= pick_idx_s;
            burst_cnt_r <= '0;
          end else begin
            state_r <= IDLE;
            grant_r <= '0;
          end
        end
        BURST: begin
          // A word transferred together with a dropped req is still written.
          if (!req[owner_r] || (valid_write && (burst_cnt_r == LAST_BEAT))) begin
            state_r      <= IDLE;
            grant_r      <= '0;
            last_grant_r <= owner_r;
          end else if (full_flag) begin
            state_r <= STALL;
          end else if (valid_write) begin
            burst_cnt_r <= burst_cnt_r + BURST_CNT_W'(1);
          end else begin
            state_r <= BURST;
          end
        end
        STALL: begin
          if (!req[owner_r]) begin
            state_r      <= IDLE;
            grant_r      <= '0;
            last_grant_r <= owner_r;
          end else if (!full_flag) begin
            state_r <= BURST;
          end else begin
            state_r <= STALL;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= '0;
        end
      endcase
    end
  end

`ifdef FIFO_WRITE_ARB_STALL_CNT_EN
  logic [15:0] stall_count_r;

  assign stall_count = stall_count_r;

  // Saturating count of STALL cycles; clear wins over increment.
  always_ff @(posedge write_clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_count_r <= 16'h0000;
    end else if (stall_clear) begin
      stall_count_r <= 16'h0000;
    end else if ((state_r == STALL) && (stall_count_r != 16'hFFFF)) begin
      stall_count_r <= stall_count_r + 16'h0001;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter (default parameters).
module tb_fifo_write_arbiter;

  logic        write_clock;
  logic        reset_n;
  logic [3:0]  req;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        full_flag;
  logic        almost_full_flag;
  logic        valid_write;
  logic [7:0]  write_data;
  logic [3:0]  grant;
  logic        busy;
`ifdef FIFO_WRITE_ARB_STALL_CNT_EN
  logic [15:0] stall_count;
  logic        stall_clear;
`endif

  int total_cnt;
  int pass_cnt;
  int fail_cnt;
  int pulses;

  fifo_write_arbiter #(
    .NUM_REQ   (4),
    .WIDTH     (8),
    .MAX_BURST (4)
  ) dut (
    .write_clock      (write_clock),
    .reset_n          (reset_n),
    .req              (req),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .full_flag        (full_flag),
    .almost_full_flag (almost_full_flag),
    .valid_write      (valid_write),
    .write_data       (write_data),
`ifdef FIFO_WRITE_ARB_STALL_CNT_EN
    .stall_count      (stall_count),
    .stall_clear      (stall_clear),
`endif
    .grant            (grant),
    .busy             (busy)
  );

  initial begin
    write_clock = 1'b0;
    forever #5 write_clock = ~write_clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs_v === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs_v, exp_v);
    end
  endtask

  task automatic obs(input string tag, input logic [3:0] eg, input logic ev,
                     input logic [3:0] er, input logic [7:0] ed);
    chk({tag, ".grant"}, {28'h0, grant}, {28'h0, eg});
    chk({tag, ".valid_write"}, {31'h0, valid_write}, {31'h0, ev});
    chk({tag, ".req_ready"}, {28'h0, req_ready}, {28'h0, er});
    chk({tag, ".busy"}, {31'h0, busy}, {31'h0, (eg != 4'h0)});
    if (ev) chk({tag, ".write_data"}, {24'h0, write_data}, {24'h0, ed});
    if (valid_write === 1'b1) pulses++;
  endtask

  task automatic cyc();
    @(posedge write_clock);
    #1;
  endtask

  initial begin
    logic [3:0] oh;
    logic [7:0] dat;
    int r;
    total_cnt = 0; pass_cnt = 0; fail_cnt = 0; pulses = 0;
    reset_n = 1'b1; req = 4'h0; req_valid = 4'h0; req_data = 32'h44332211;
    full_flag = 1'b0; almost_full_flag = 1'b0;
`ifdef FIFO_WRITE_ARB_STALL_CNT_EN
    stall_clear = 1'b0;
`endif
    #1 reset_n = 1'b0;
    repeat (2) @(posedge write_clock);
    #1 obs("reset", 4'h0, 1'b0, 4'h0, 8'h00);
    #2 reset_n = 1'b1;
    cyc();

    // Round robin: all four request continuously -> 0,1,2,3,0, four words each.
    req = 4'hF; req_valid = 4'hF; pulses = 0;
    for (int b = 0; b < 5; b++) begin
      r   = b % 4;
      oh  = 4'(4'b0001 << r);
      dat = 8'(8'h11 * (r + 1));
      #1 obs("rr_idle", 4'h0, 1'b0, 4'h0, 8'h00);
      cyc();
      for (int k = 0; k < 4; k++) begin
        #1 obs("rr_beat", oh, 1'b1, oh, dat);
        cyc();
      end
    end
    chk("rr_pulses", pulses, 32'd20);
    req = 4'h0; req_valid = 4'h0;
    #1 obs("rr_end", 4'h0, 1'b0, 4'h0, 8'h00);
    cyc();

    // Early release: requester 2 drops req alongside its second word.
    req = 4'b0100; req_valid = 4'b0100; pulses = 0;
    #1 obs("er_idle", 4'h0, 1'b0, 4'h0, 8'h00);
    cyc();
    #1 obs("er_w1", 4'b0100, 1'b1, 4'b0100, 8'h33);
    cyc();
    req = 4'h0;
    #1 obs("er_w2", 4'b0100, 1'b1, 4'b0100, 8'h33);
    cyc();
    #1 obs("er_rel", 4'h0, 1'b0, 4'h0, 8'h00);
    chk("er_pulses", pulses, 32'd2);
    req = 4'b1001; req_valid = 4'h0;
    cyc();
    req = 4'h0;
    #1 obs("er_next", 4'b1000, 1'b0, 4'b1000, 8'h00);
    cyc();
    #1 obs("er_idle2", 4'h0, 1'b0, 4'h0, 8'h00);

    // Full stall after two words, held five cycles, one bubble, then two more.
    req = 4'b0001; req_valid = 4'b0001; pulses = 0;
    cyc();
    #1 obs("fs_w1", 4'b0001, 1'b1, 4'b0001, 8'h11);
    cyc();
    #1 obs("fs_w2", 4'b0001, 1'b1, 4'b0001, 8'h11);
    cyc();
    full_flag = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 obs("fs_full", 4'b0001, 1'b0, 4'h0, 8'h00);
      cyc();
    end
    full_flag = 1'b0;
    #1 obs("fs_bubble", 4'b0001, 1'b0, 4'h0, 8'h00);
    cyc();
`ifdef FIFO_WRITE_ARB_STALL_CNT_EN
    chk("fs_stall_count", {16'h0, stall_count}, 32'd5);
    stall_clear = 1'b1;
`endif
    #1 obs("fs_w3", 4'b0001, 1'b1, 4'b0001, 8'h11);
    cyc();
`ifdef FIFO_WRITE_ARB_STALL_CNT_EN
    stall_clear = 1'b0;
    chk("fs_stall_clear", {16'h0, stall_count}, 32'd0);
`endif
    #1 obs("fs_w4", 4'b0001, 1'b1, 4'b0001, 8'h11);
    cyc();
    #1 obs("fs_done", 4'h0, 1'b0, 4'h0, 8'h00);
    chk("fs_pulses", pulses, 32'd4);
    req = 4'h0; req_valid = 4'h0;

    // Almost full blocks a new burst but not a running one.
    almost_full_flag = 1'b1; req = 4'b0010; req_valid = 4'b0010; pulses = 0;
    cyc();
    #1 obs("af_block1", 4'h0, 1'b0, 4'h0, 8'h00);
    cyc();
    #1 obs("af_block2", 4'h0, 1'b0, 4'h0, 8'h00);
    almost_full_flag = 1'b0;
    cyc();
    almost_full_flag = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 obs("af_beat", 4'b0010, 1'b1, 4'b0010, 8'h22);
      cyc();
    end
    #1 obs("af_after", 4'h0, 1'b0, 4'h0, 8'h00);
    chk("af_pulses", pulses, 32'd4);
    almost_full_flag = 1'b0; req = 4'h0; req_valid = 4'h0;
    cyc();

    // Asynchronous reset in the middle of requester 2's burst.
    req = 4'b1100; req_valid = 4'b1100;
    #1 obs("ar_idle", 4'h0, 1'b0, 4'h0, 8'h00);
    cyc();
    #1 obs("ar_w1", 4'b0100, 1'b1, 4'b0100, 8'h33);
    cyc();
    #1 obs("ar_w2", 4'b0100, 1'b1, 4'b0100, 8'h33);
    #2 reset_n = 1'b0;
    #1 obs("ar_async", 4'h0, 1'b0, 4'h0, 8'h00);
    req = 4'hF; req_valid = 4'hF;
    #2 reset_n = 1'b1;
    cyc();
    #1 obs("ar_prio0", 4'b0001, 1'b1, 4'b0001, 8'h11);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
